bcd_serial_addsub: RTL and testbench

//  Multi-digit packed-BCD adder/subtractor. Processes one decimal digit per clock, least significant first.

---
 rtl/bcd_serial_addsub.sv | 174 +++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, least significant first,
// with valid/ready handshakes on operands and result. Subtraction adds the nine's complement of B plus one.
module bcd_serial_addsub #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r, state_next_s;
   logic [W-1:0]    a_r, b_r, res_r, sum_r;
   logic [W-1:0]    res_next_s;
   logic [KW-1:0]   k_r;
   logic            sub_r, carry_r, err_pend_r;
   logic            in_ready_r, out_valid_r, cout_r, err_r;
   logic [4:0]      dig_s;
   logic            accept_s, release_s, last_s;

   // Any nibble outside 0..9 marks the operand as illegal BCD.
   function automatic logic bcd_bad(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | (v[4*i +: 4] > 4'd9);
      end
      return bad;
   endfunction

   // One decimal digit step; returns {carry_out, digit}.
   function automatic logic [4:0] digit_op(input logic [3:0] ad, input logic [3:0] bdig,
                                           input logic is_sub, input logic c);
      logic [3:0] bd;
      logic [4:0] t;
      logic [4:0] r;
      bd = is_sub ? (4'd9 - bdig) : bdig;
      t  = {1'b0, ad} + {1'b0, bd} + {4'd0, c};
      if (t >= 5'd10) begin
         r = {1'b1, t[3:0] - 4'd10};
      end else begin
         r = {1'b0, t[3:0]};
      end
      return r;
   endfunction

   assign accept_s  = in_valid && in_ready_r;
   assign release_s = out_valid_r && out_ready;
   assign last_s    = (k_r == KLAST);

   // Current digit result from the low nibbles of the shifting operand registers.
   always_comb begin
      dig_s = digit_op(a_r[3:0], b_r[3:0], sub_r, carry_r);
   end

   // Result digits enter at the top and shift down, so after DIGITS steps they sit in place.
   generate
      if (DIGITS == 1) begin : g_res1
         assign res_next_s = dig_s[3:0];
      end else begin : g_resn
         assign res_next_s = {dig_s[3:0], res_r[W-1:4]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_next_s = RUN;
            else          state_next_s = IDLE;
         end
         RUN: begin
            if (last_s) state_next_s = DONE;
            else        state_next_s = RUN;
         end
         DONE: begin
            if (release_s) state_next_s = IDLE;
            else           state_next_s = DONE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Datapath and registered outputs; sum/cout/err only change when a result completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r         <= '0;
         b_r         <= '0;
         res_r       <= '0;
         sum_r       <= '0;
         k_r         <= '0;
         sub_r       <= 1'b0;
         carry_r     <= 1'b0;
         err_pend_r  <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         cout_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r        <= a;
                  b_r        <= b;
                  sub_r      <= sub;
                  carry_r    <= sub ? 1'b1 : cin;
                  k_r        <= '0;
                  err_pend_r <= bcd_bad(a) | bcd_bad(b);
                  in_ready_r <= 1'b0;
               end
            end
            RUN: begin
               a_r     <= a_r >> 3'd4;
               b_r     <= b_r >> 3'd4;
               carry_r <= dig_s[4];
               res_r   <= res_next_s;
               k_r     <= k_r + 1'b1;
               if (last_s) begin
                  sum_r       <= res_next_s;
                  cout_r      <= dig_s[4];
                  err_r       <= err_pend_r;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (release_s) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub (DIGITS=4): stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every result handshake.
module tb_bcd_serial_addsub;

   localparam int DIGITS = 4;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        e;
   } exp_t;

   logic        clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, err;
   logic [15:0] a, b, sum;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: each result handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("sum", {16'd0, sum}, {16'd0, x.s});
            check("cout", {31'd0, cout}, {31'd0, x.c});
            check("err", {31'd0, err}, {31'd0, x.e});
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
   endtask

   // Full operation: push expectation, drive one accept, check latency and in_ready during RUN.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic ts, input logic [15:0] es, input logic ec, input logic ee);
      int n;
      exp_t x;
      wait_ready();
      x.s = es; x.c = ec; x.e = ee;
      sb.push_back(x);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'hxxxx; b = 16'hxxxx;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid) break;
         check("in_ready_run", {31'd0, in_ready}, 32'd0);
      end
      check("latency", n, DIGITS);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout_err", {30'd0, cout, err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
      run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h0905, 16'h0095, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0);
      run_op(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1);
      run_op(16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

      // Backpressure: result held in DONE while the next operand waits on in_valid.
      out_ready = 1'b0;
      wait_ready();
      sb.push_back('{s: 16'h6912, c: 1'b0, e: 1'b0});
      a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h0042; b = 16'h0058;
      repeat (DIGITS) @(posedge clk);
      #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_sum", {16'd0, sum}, 32'h6912);
      end
      sb.push_back('{s: 16'h0100, c: 1'b0, e: 1'b0});
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
      check("release_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("reaccept_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      repeat (DIGITS) @(posedge clk);
      #1;
      check("reaccept_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of an operation: nothing may emerge from it.
      wait_ready();
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_sum", {16'd0, sum}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("no_stale_valid", {31'd0, out_valid}, 32'd0);
      run_op(16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
